blink_sched: RTL and testbench

BLINK_SCHED -- requirements
Module: blink_sched

---
 rtl/blink_sched.sv | 185 ++++++++++++++++++
 tb/tb_blink_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/blink_sched.sv
// Multi-requester LED blink scheduler: grants the LED to one requester, plays its blink
// pattern, inserts a gap, then pulses done. Define BLINK_SCHED_RR_EN for round-robin arbitration.
module blink_sched #(
  parameter int unsigned HALF_PERIOD = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] count,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic        out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP,
    S_ZERO
  } state_t;

  localparam logic [31:0] TICK_AT = 32'(HALF_PERIOD - 1);

  state_t      r_state;
  logic [31:0] r_timer;
  logic [3:0]  r_rem;
  logic        r_gap_half;
  logic [1:0]  r_owner;
  logic [3:0]  r_grant;
  logic [3:0]  r_done;
  logic        r_busy;
  logic        r_out;
`ifdef BLINK_SCHED_RR_EN
  logic [1:0]  r_ptr;
  logic [1:0]  w_cand;
`endif

  logic        w_tick;
  logic        w_abort;
  logic        w_win_valid;
  logic [1:0]  w_win_idx;
  logic [3:0]  w_win_cnt;

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign out   = r_out;

  assign w_tick    = (r_timer == TICK_AT);
  assign w_abort   = ~req[r_owner];
  assign w_win_cnt = count[{w_win_idx, 2'b00} +: 4];

  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
`ifdef BLINK_SCHED_RR_EN
    w_cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_win_valid && req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
`else
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_win_valid && req[k]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'(k);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_rem      <= '0;
      r_gap_half <= 1'b0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_out      <= 1'b0;
`ifdef BLINK_SCHED_RR_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_done  <= '0;
      r_timer <= w_tick ? '0 : r_timer + 32'd1;

      unique case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_grant <= 4'b0001 << w_win_idx;
            r_busy  <= 1'b1;
            r_owner <= w_win_idx;
`ifdef BLINK_SCHED_RR_EN
            r_ptr   <= w_win_idx + 2'd1;
`endif
            // remaining holds blinks still owed after the current one
            if (w_win_cnt == 4'd0) begin
              r_state <= S_ZERO;
              r_out   <= 1'b0;
            end else begin
              r_state <= S_ON;
              r_out   <= 1'b1;
              r_rem   <= w_win_cnt - 4'd1;
              r_timer <= '0;
            end
          end
        end

        S_ON: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_out   <= 1'b0;
          end else if (w_tick) begin
            r_state <= S_OFF;
            r_out   <= 1'b0;
            r_timer <= '0;
          end
        end

        S_OFF: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_out   <= 1'b0;
          end else if (w_tick) begin
            r_timer <= '0;
            if (r_rem == 4'd0) begin
              r_state    <= S_GAP;
              r_gap_half <= 1'b0;
            end else begin
              r_state <= S_ON;
              r_rem   <= r_rem - 4'd1;
              r_out   <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_out   <= 1'b0;
          end else if (w_tick) begin
            // the gap is two half-periods; the timer wraps between them
            if (r_gap_half) begin
              r_state <= S_IDLE;
              r_done  <= r_grant;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_gap_half <= 1'b1;
            end
          end
        end

        S_ZERO: begin
          r_state <= S_IDLE;
          r_done  <= r_grant;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched with HALF_PERIOD=4: blink timing, zero count,
// arbitration (mode follows BLINK_SCHED_RR_EN), abort and mid-sequence reset.
module tb_blink_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] count;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        out;

  int n_checks = 0;
  int n_errors = 0;

  blink_sched #(.HALF_PERIOD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .count (count),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 4'b0000);
    chk({tag, "_done"}, done, 4'b0000);
    chk({tag, "_busy"}, {3'b000, busy}, 4'b0000);
    chk({tag, "_out"}, {3'b000, out}, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       e_out;
    logic [3:0] exp_g [3];

    rst_n = 1'b0;
    req   = 4'b0000;
    count = 16'h0000;
    #1;
    chk_all_zero("rst_async");
    step();
    step();
    chk_all_zero("rst_hold");
    rst_n = 1'b1;

    // 2 blinks then 8-cycle gap, done 24 cycles after the grant edge
    req   = 4'b0001;
    count = 16'h0002;
    step();
    for (int i = 0; i < 24; i++) begin
      if (i == 1) count = 16'h000F;
      e_out = (i < 4) || (i >= 8 && i < 12);
      chk("t1_out", {3'b000, out}, {3'b000, e_out});
      chk("t1_grant", grant, 4'b0001);
      chk("t1_done", done, 4'b0000);
      step();
    end
    chk("t1_done_pulse", done, 4'b0001);
    chk("t1_grant_end", grant, 4'b0000);
    chk("t1_busy_end", {3'b000, busy}, 4'b0000);
    chk("t1_out_end", {3'b000, out}, 4'b0000);
    req = 4'b0000;
    step();
    chk("t1_done_clr", done, 4'b0000);
    chk("t1_no_regrant", grant, 4'b0000);

    // zero blink count: one cycle of grant with LED off, then done
    req   = 4'b0100;
    count = 16'h0000;
    step();
    chk("t2_grant", grant, 4'b0100);
    chk("t2_out", {3'b000, out}, 4'b0000);
    chk("t2_done0", done, 4'b0000);
    step();
    chk("t2_done", done, 4'b0100);
    chk("t2_grant_end", grant, 4'b0000);
    chk("t2_out_end", {3'b000, out}, 4'b0000);
    req = 4'b0000;
    step();
    chk("t2_done_clr", done, 4'b0000);

`ifdef BLINK_SCHED_RR_EN
    req      = 4'b0101;
    count    = 16'h0101;
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0100;
    exp_g[2] = 4'b0001;
`else
    req      = 4'b1010;
    count    = 16'h1010;
    exp_g[0] = 4'b0010;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b0010;
`endif
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_grant", grant, exp_g[k]);
      for (int j = 1; j < 16; j++) begin
        step();
        chk("t3_grant_hold", grant, exp_g[k]);
      end
      step();
      chk("t3_gap_grant", grant, 4'b0000);
      chk("t3_done", done, exp_g[k]);
      if (k == 2) req = 4'b0000;
      step();
    end
    chk("t3_idle", grant, 4'b0000);

    // abort two cycles into the second ON half-period
    req   = 4'b0010;
    count = 16'h0020;
    step();
    chk("t4_grant", grant, 4'b0010);
    repeat (9) step();
    chk("t4_on2", {3'b000, out}, 4'b0001);
    req = 4'b0000;
    step();
    chk_all_zero("t4_abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_no_done", done, 4'b0000);
    end

    // reset asserted during GAP, then a clean restart
    req   = 4'b0001;
    count = 16'h0001;
    step();
    chk("t5_grant", grant, 4'b0001);
    repeat (10) step();
    chk("t5_gap_out", {3'b000, out}, 4'b0000);
    chk("t5_gap_grant", grant, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst_async");
    step();
    chk_all_zero("t5_rst_hold");
    rst_n = 1'b1;
    step();
    chk("t5_restart_grant", grant, 4'b0001);
    chk("t5_restart_out", {3'b000, out}, 4'b0001);
    repeat (16) step();
    chk("t5_restart_done", done, 4'b0001);
    chk("t5_restart_end", grant, 4'b0000);
    req = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
